// File: rtl/wb_write_arbiter.sv
// Write-back arbiter for the integer register file's single write port.
// Single-cycle ALU results take priority. Long-latency results (load/mul/div)
// wait in a small circular FIFO. pending_mask tells issue logic which
// registers still have a queued write.
// Optional build macro: WB_PERF_CNT_EN adds the perf_stall_cnt/perf_full_cnt
// saturating counters.
//
// state | meaning
// ------+----------------------------------------------------------------
// (none)| no explicit FSM; the state is the FIFO occupancy and the starvation counter
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_rd,
  input  logic [31:0] l_data,
  output logic        we3,
  output logic [4:0]  rd,
  output logic [31:0] wd3,
  output logic [31:0] pending_mask,
  output logic        a_stall
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_full_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);

  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          a_stall_q, a_stall_d;
  logic          we3_q, we3_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wd3_q, wd3_d;

  logic          fifo_empty, fifo_full;
  logic          sel_a, pop, push, store, blocking;
  logic [31:0]   mask_c;
  logic [PW-1:0] off_c;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  // A full FIFO refuses pushes even when it pops this cycle (pre-pop count).
  assign l_ready    = rst_n & ~fifo_full;

  // An A write always wins, even during a_stall (a protocol violation upstream).
  assign sel_a    = a_valid && (a_rd != 5'd0);
  assign pop      = !sel_a && !fifo_empty;
  assign push     = l_valid && l_ready;
  // Pushes to x0 are acknowledged but never stored.
  assign store    = push && (l_rd != 5'd0);
  assign blocking = sel_a && !fifo_empty;

  // Next-state for pointers, occupancy, starvation and the write port.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    a_stall_d = 1'b0;
    we3_d     = 1'b0;
    rd_d      = rd_q;
    wd3_d     = wd3_q;

    if (store) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(store) - CW'(pop);

    if (sel_a) begin
      we3_d = 1'b1;
      rd_d  = a_rd;
      wd3_d = a_data;
    end else if (pop) begin
      we3_d = 1'b1;
      rd_d  = mem_rd_q[rd_ptr_q];
      wd3_d = mem_data_q[rd_ptr_q];
    end

    // The counter saturates so a violating A write during a_stall keeps the stall asserted.
    if (pop) begin
      starve_d = '0;
    end else if (blocking) begin
      if (starve_q == STARVE_TOP) a_stall_d = 1'b1;
      else                        starve_d  = starve_q + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      a_stall_q <= 1'b0;
      we3_q     <= 1'b0;
      rd_q      <= 5'd0;
      wd3_q     <= 32'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      a_stall_q <= a_stall_d;
      we3_q     <= we3_d;
      rd_q      <= rd_d;
      wd3_q     <= wd3_d;
    end
  end

  // FIFO storage. It is not reset because only slots inside the occupancy window are read.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_rd_q[wr_ptr_q]   <= l_rd;
      mem_data_q[wr_ptr_q] <= l_data;
    end
  end

  // OR together the one-hot destinations of every occupied slot.
  always_comb begin
    mask_c = 32'd0;
    off_c  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_c = PW'(i) - rd_ptr_q;
      if ({1'b0, off_c} < count_q) mask_c[mem_rd_q[i]] = 1'b1;
    end
    mask_c[0] = 1'b0;
  end

  assign pending_mask = mask_c;
  assign we3          = we3_q;
  assign rd           = rd_q;
  assign wd3          = wd3_q;
  assign a_stall      = a_stall_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_full_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_full_q  <= 32'd0;
    end else begin
      if (a_stall_q && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
      if (l_valid && !l_ready && (perf_full_q != 32'hFFFF_FFFF))
        perf_full_q <= perf_full_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_full_cnt  = perf_full_q;
`endif

endmodule
